// File: rtl/rotate_fb_sched_pkg.sv
// Shared types for the rotation frame-store triple-buffer scheduler:
// buffer lifecycle states, buffer index type and a lowest-index state finder.
package rotate_fb_pkg;

  localparam int NBUF = 3;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } buf_state_t;

  typedef logic [1:0] sel_t;

  typedef struct packed {
    logic hit;
    sel_t idx;
  } find_t;

  // Lowest buffer index currently in state tgt; hit=0 when none matches.
  function automatic find_t find_lowest(input buf_state_t st [NBUF], input buf_state_t tgt);
    find_t r;
    r.hit = 1'b0;
    r.idx = 2'd0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (st[i] == tgt) begin
        r.hit = 1'b1;
        r.idx = sel_t'(i);
      end else begin
        r.hit = r.hit;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rotate_fb_sched_if.sv
// Video-timing inputs and buffer-selection outputs of the triple-buffer scheduler.
interface rotate_fb_sched_if #(parameter int AW = 18);
  logic          hblank_in;
  logic          vblank_in;
  logic          rd_frame;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_base;
  logic [1:0]    rd_sel;
  logic [AW-1:0] rd_base;
  logic          rd_valid;
  logic [7:0]    drop_cnt;
  logic [7:0]    rep_cnt;

  modport master (
    output hblank_in, vblank_in, rd_frame,
    input  wr_sel, wr_base, rd_sel, rd_base, rd_valid, drop_cnt, rep_cnt
  );

  modport slave (
    input  hblank_in, vblank_in, rd_frame,
    output wr_sel, wr_base, rd_sel, rd_base, rd_valid, drop_cnt, rep_cnt
  );
endinterface

// File: rtl/rotate_fb_sched_sat_cnt.sv
// 8-bit counter that sticks at 255; clear has priority over increment.
module fb_sat_cnt8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt
);
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/rotate_fb_sched.sv
// Triple-buffer scheduler: picks the buffer the input side writes and the one scan-out reads,
// so output never tears and never waits. Write boundary resolves before read boundary.
module rotate_fb_sched
  import rotate_fb_pkg::*;
#(
  parameter int BUFSIZE      = 76800,
  parameter int AW           = 18,
  parameter int HEIGHT       = 240,
  parameter int STALL_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  rotate_fb_sched_if.slave   bus
);
  localparam logic [11:0] LINE_MAX = 12'hFFF;
  localparam logic [7:0]  STALL_M1 = 8'(STALL_FRAMES - 1);

  function automatic logic [AW-1:0] base_of(input sel_t s);
    case (s)
      2'd0:    return {AW{1'b0}};
      2'd1:    return AW'(BUFSIZE);
      2'd2:    return AW'(2 * BUFSIZE);
      default: return {AW{1'b0}};
    endcase
  endfunction

  buf_state_t    st_q [NBUF];
  buf_state_t    st_d [NBUF];
  sel_t          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [AW-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
  logic          rd_valid_q, rd_valid_d;
  logic          vblank_d_q, hblank_d_q;
  logic [11:0]   line_q, line_d;
  logic          vrise_s, hrise_s;
  logic          drop_inc, rep_inc, stall_inc, stall_clr;
  logic [7:0]    drop_cnt, rep_cnt, stall_cnt;
  find_t         free_f, ready_f;

  assign vrise_s = bus.vblank_in & ~vblank_d_q;
  assign hrise_s = bus.hblank_in & ~hblank_d_q;

  always_comb begin
    st_d       = st_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    rd_valid_d = rd_valid_q;
    drop_inc   = 1'b0;
    rep_inc    = 1'b0;
    stall_inc  = 1'b0;
    stall_clr  = 1'b0;
    free_f     = '0;
    ready_f    = '0;

    if (vrise_s) begin
      line_d = 12'd0;
    end else if (hrise_s && !bus.vblank_in && (line_q != LINE_MAX)) begin
      line_d = line_q + 12'd1;
    end else begin
      line_d = line_q;
    end

    // Only a frame with exactly HEIGHT lines is published; short/long frames are rewritten in place.
    if (vrise_s && (line_q == 12'(HEIGHT))) begin
      for (int i = 0; i < NBUF; i++) begin
        case (st_q[i])
          READY: begin
            st_d[i]  = FREE;
            drop_inc = 1'b1;
          end
          WRITING: st_d[i] = READY;
          default: st_d[i] = st_q[i];
        endcase
      end
      free_f = find_lowest(st_d, FREE);
      if (free_f.hit) begin
        st_d[free_f.idx] = WRITING;
        wr_sel_d         = free_f.idx;
      end else begin
        wr_sel_d = wr_sel_q;
      end
      stall_clr = 1'b1;
    end else begin
      stall_clr = 1'b0;
    end

    if (bus.rd_frame) begin
      ready_f = find_lowest(st_d, READY);
      if (ready_f.hit) begin
        for (int i = 0; i < NBUF; i++) begin
          if (st_d[i] == READING) begin
            st_d[i] = FREE;
          end else begin
            st_d[i] = st_d[i];
          end
        end
        st_d[ready_f.idx] = READING;
        rd_sel_d          = ready_f.idx;
        rd_valid_d        = 1'b1;
      end else begin
        stall_inc = 1'b1;
        // A repeat is only counted when the scanned buffer is still shown, not blanked.
        if (stall_cnt >= STALL_M1) begin
          rd_valid_d = 1'b0;
        end else begin
          rep_inc = rd_valid_q;
        end
      end
    end else begin
      rd_sel_d = rd_sel_q;
    end

    wr_base_d = base_of(wr_sel_d);
    rd_base_d = base_of(rd_sel_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q[0]    <= WRITING;
      st_q[1]    <= FREE;
      st_q[2]    <= FREE;
      wr_sel_q   <= 2'd0;
      rd_sel_q   <= 2'd0;
      wr_base_q  <= {AW{1'b0}};
      rd_base_q  <= {AW{1'b0}};
      rd_valid_q <= 1'b0;
      vblank_d_q <= 1'b0;
      hblank_d_q <= 1'b0;
      line_q     <= 12'd0;
    end else begin
      st_q       <= st_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_base_q  <= wr_base_d;
      rd_base_q  <= rd_base_d;
      rd_valid_q <= rd_valid_d;
      vblank_d_q <= bus.vblank_in;
      hblank_d_q <= bus.hblank_in;
      line_q     <= line_d;
    end
  end

  fb_sat_cnt8 u_drop  (.clk(clk), .reset(reset), .inc(drop_inc),  .clr(1'b0),      .cnt(drop_cnt));
  fb_sat_cnt8 u_rep   (.clk(clk), .reset(reset), .inc(rep_inc),   .clr(1'b0),      .cnt(rep_cnt));
  fb_sat_cnt8 u_stall (.clk(clk), .reset(reset), .inc(stall_inc), .clr(stall_clr), .cnt(stall_cnt));

  assign bus.wr_sel   = wr_sel_q;
  assign bus.wr_base  = wr_base_q;
  assign bus.rd_sel   = rd_sel_q;
  assign bus.rd_base  = rd_base_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.drop_cnt = drop_cnt;
  assign bus.rep_cnt  = rep_cnt;
endmodule

// File: tb/tb_rotate_fb_sched.sv
// Scoreboard bench for rotate_fb_sched: directed frames push expected outputs, a negedge
// monitor pops and compares them and checks the buffer-selection invariants every cycle.
module tb_rotate_fb_sched;
  localparam int H       = 16;
  localparam int BUFSIZE = 76800;
  localparam int AW      = 18;

  typedef struct {
    string name;
    int    at;
    int    wr;
    int    rd;
    int    vld;
    int    drop;
    int    rep;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q [$];

  rotate_fb_sched_if #(.AW(AW)) bus ();

  rotate_fb_sched #(.BUFSIZE(BUFSIZE), .AW(AW), .HEIGHT(H), .STALL_FRAMES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit fok(input int e, input int a);
    return (e < 0) || (e == a);
  endfunction

  // Invariants every cycle, then any expectations due this cycle.
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if ((bus.rd_valid && (bus.wr_sel == bus.rd_sel)) || (bus.wr_sel > 2'd2) || (bus.rd_sel > 2'd2) ||
        (int'(bus.wr_base) != int'(bus.wr_sel) * BUFSIZE) || (int'(bus.rd_base) != int'(bus.rd_sel) * BUFSIZE)) begin
      n_fail++;
      $display("FAIL invariant cyc=%0d: wr_sel=%0d rd_sel=%0d rd_valid=%0d wr_base=%0d rd_base=%0d, required distinct sels when valid and base=sel*%0d",
               cyc, bus.wr_sel, bus.rd_sel, bus.rd_valid, bus.wr_base, bus.rd_base, BUFSIZE);
    end
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (!(fok(e.wr, int'(bus.wr_sel)) && fok(e.rd, int'(bus.rd_sel)) && fok(e.vld, int'(bus.rd_valid)) &&
            fok(e.drop, int'(bus.drop_cnt)) && fok(e.rep, int'(bus.rep_cnt)) &&
            (e.wr < 0 || int'(bus.wr_base) == e.wr * BUFSIZE) && (e.rd < 0 || int'(bus.rd_base) == e.rd * BUFSIZE))) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got wr=%0d rd=%0d vld=%0d drop=%0d rep=%0d wrb=%0d rdb=%0d; want wr=%0d rd=%0d vld=%0d drop=%0d rep=%0d (-1=any)",
                 e.name, cyc, bus.wr_sel, bus.rd_sel, bus.rd_valid, bus.drop_cnt, bus.rep_cnt,
                 bus.wr_base, bus.rd_base, e.wr, e.rd, e.vld, e.drop, e.rep);
      end
    end
  end

  task automatic push(input string nm, input int at, input int w, input int r, input int v, input int d, input int p);
    exp_t e;
    e.name = nm; e.at = at; e.wr = w; e.rd = r; e.vld = v; e.drop = d; e.rep = p;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      bus.hblank_in = 1'b1; step();
      bus.hblank_in = 1'b0; step();
    end
  endtask

  // n active lines, then vblank rise (optionally with rd_frame on the same clock).
  task automatic frame(input int n, input bit rd, input bit chk, input string nm,
                       input int w, input int r, input int v, input int d, input int p);
    lines(n);
    bus.vblank_in = 1'b1;
    bus.rd_frame  = rd;
    if (chk) push(nm, cyc + 1, w, r, v, d, p);
    step();
    bus.rd_frame = 1'b0;
    step();
    bus.vblank_in = 1'b0;
    step();
  endtask

  task automatic rdpulse(input bit chk, input string nm,
                         input int w, input int r, input int v, input int d, input int p);
    bus.rd_frame = 1'b1;
    if (chk) push(nm, cyc + 1, w, r, v, d, p);
    step();
    bus.rd_frame = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hblank_in = 1'b0;
    bus.vblank_in = 1'b0;
    bus.rd_frame  = 1'b0;
    step();
    push("reset", cyc, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();

    frame(H - 1, 1'b0, 1'b1, "short_frame", 0, 0, 0, 0, 0);
    rdpulse(1'b1, "rd_after_short", 0, 0, 0, 0, 0);

    frame(H, 1'b0, 1'b1, "first_frame", 1, 0, 0, 0, 0);
    rdpulse(1'b1, "first_read", 1, 0, 1, 0, 0);

    frame(H, 1'b0, 1'b1, "triple_1", 2, 0, 1, 0, 0);
    frame(H, 1'b0, 1'b1, "triple_2", 1, 0, 1, 1, 0);
    frame(H, 1'b0, 1'b1, "triple_3", 2, 0, 1, 2, 0);
    rdpulse(1'b1, "triple_read", 2, 1, 1, 2, 0);

    for (int k = 1; k <= 7; k++) rdpulse(1'b1, "repeat", 2, 1, 1, 2, k);
    rdpulse(1'b1, "stall_8th", 2, 1, 0, 2, 7);

    frame(H, 1'b1, 1'b1, "same_clk", 0, 2, 1, 2, 7);

    // Reset mid-line: hblank high, reset in the middle of a clock period.
    lines(H / 2);
    bus.hblank_in = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    bus.hblank_in = 1'b0;
    push("mid_reset", cyc, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    step();
    frame(H / 2, 1'b0, 1'b1, "post_reset_partial", 0, 0, 0, 0, 0);

    for (int f = 0; f < 270; f++) frame(H, 1'b0, 1'b0, "", 0, 0, 0, 0, 0);
    push("drop_sat", cyc, -1, -1, 0, 255, 0);
    step();

    for (int f = 0; f < 40; f++) begin
      frame(H, 1'b0, 1'b0, "", 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 5)) step();
        rdpulse(k == 7, "rand_phase_valid", -1, -1, 1, 255, -1);
      end
    end
    push("rep_sat", cyc, -1, -1, 1, 255, 255);
    repeat (4) step();

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: expectation never checked (due cyc=%0d, now %0d)", e.name, e.at, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
